cpu_io_tx: RTL and testbench

//  Serial result transmitter: the outbound counterpart of the start/bit serial loader in cpu_io_fsm.
//  On a send request it latches one ALU result byte plus the C/Z/V/N flags.
//  It emits them as a framed, even-parity serial stream on dedicated uio output pins.

---
 rtl/cpu_io_tx_if.sv | 25 ++
 rtl/cpu_io_tx.sv | 169 ++++++++++++++++
 tb/tb_cpu_io_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_io_tx_if.sv
// rtl/cpu_io_tx_if.sv - request and serial-line bundle between the control path and the result transmitter
interface cpu_io_tx_if #(
    parameter int DATA_W = 8,
    parameter int FLAG_W = 4
);
    logic              send_i;
    logic [DATA_W-1:0] data_i;
    logic [FLAG_W-1:0] flag_i;
    logic              tx_start_o;
    logic              tx_bit_o;
    logic              tx_strobe_o;
    logic              busy_o;
    logic              done_o;
    logic              drop_o;

    modport master (
        output send_i, data_i, flag_i,
        input  tx_start_o, tx_bit_o, tx_strobe_o, busy_o, done_o, drop_o
    );

    modport slave (
        input  send_i, data_i, flag_i,
        output tx_start_o, tx_bit_o, tx_strobe_o, busy_o, done_o, drop_o
    );
endinterface

// File: rtl/cpu_io_tx.sv
// rtl/cpu_io_tx.sv - framed even-parity serial transmitter for one ALU result byte plus flags
module cpu_io_tx #(
    parameter int DATA_W     = 8,
    parameter int FLAG_W     = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    cpu_io_tx_if.slave bus
);
    localparam int PAY_W = DATA_W + FLAG_W;
    localparam int CNT_W = 8;
    localparam int IDX_W = $clog2(PAY_W);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_CNT = CNT_W'(BIT_CYCLES / 2);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PAY_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic [PAY_W-1:0]  shreg;
    logic [PAY_W-1:0]  shreg_n;
    logic              parity;
    logic              parity_n;
    logic [FLAG_W-1:0] flag_rev;
    logic              period_end;

    logic start_q;
    logic bit_q;
    logic strobe_q;
    logic busy_q;
    logic done_q;
    logic start_n;
    logic bit_n;
    logic strobe_n;
    logic busy_n;
    logic done_n;

    // Flags go out C first, so reverse them to let the shifter always emit its MSB
    always_comb begin
        flag_rev = '0;
        for (int i = 0; i < FLAG_W; i++) begin
            flag_rev[FLAG_W-1-i] = bus.flag_i[i];
        end
    end

    // Next-state, counters, shifter and the next value of every registered output
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        shreg_n    = shreg;
        parity_n   = parity;
        period_end = (cnt == LAST_CNT);

        unique case (state)
            IDLE: begin
                if (bus.send_i) begin
                    state_n  = START;
                    cnt_n    = '0;
                    idx_n    = '0;
                    shreg_n  = {bus.data_i, flag_rev};
                    parity_n = ^{bus.data_i, bus.flag_i};
                end
            end
            START: begin
                if (period_end) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (period_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg << 1;
                    if (idx == LAST_IDX) begin
                        state_n = PARITY;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (period_end) begin
                    state_n = STOP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (period_end) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the flops line up with the state they describe
        start_n  = (state_n == START);
        strobe_n = (state_n != IDLE) && (cnt_n == STROBE_CNT);
        busy_n   = (state_n != IDLE);
        done_n   = (state_n == STOP) && (cnt_n == LAST_CNT);
        unique case (state_n)
            DATA:    bit_n = shreg_n[PAY_W-1];
            PARITY:  bit_n = parity_n;
            STOP:    bit_n = 1'b1;
            default: bit_n = 1'b0;
        endcase
    end

    // State, datapath and output registers; reset abandons any frame in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
            start_q  <= 1'b0;
            bit_q    <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            parity   <= parity_n;
            start_q  <= start_n;
            bit_q    <= bit_n;
            strobe_q <= strobe_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign bus.tx_start_o  = start_q;
    assign bus.tx_bit_o    = bit_q;
    assign bus.tx_strobe_o = strobe_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    // A request seen while busy is discarded and flagged in the same cycle it arrives
    assign bus.drop_o      = bus.send_i & busy_q;
endmodule

// File: tb/tb_cpu_io_tx.sv
// tb/tb_cpu_io_tx.sv - directed frame checks for cpu_io_tx at two bit-period settings
module tb_cpu_io_tx;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_io_tx_if #(.DATA_W(8), .FLAG_W(4)) bus_a ();
    cpu_io_tx_if #(.DATA_W(8), .FLAG_W(4)) bus_b ();

    cpu_io_tx #(.DATA_W(8), .FLAG_W(4), .BIT_CYCLES(4)) dut_a (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_a)
    );

    cpu_io_tx #(.DATA_W(8), .FLAG_W(4), .BIT_CYCLES(2)) dut_b (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [7:0]  d;
        logic [3:0]  f;
        logic [11:0] bits;
        logic        par;
        int          chg;
        int          drop_a;
        int          drop_b;
    } vec_t;

    vec_t vecs [6];
    vec_t v_drop;
    vec_t v_next;

    task automatic drive(input int sel, input logic s, input logic [7:0] d, input logic [3:0] f);
        if (sel == 0) begin
            bus_a.send_i = s;
            bus_a.data_i = d;
            bus_a.flag_i = f;
        end else begin
            bus_b.send_i = s;
            bus_b.data_i = d;
            bus_b.flag_i = f;
        end
    endtask

    // {start, bit, strobe, busy, done, drop}
    function automatic logic [5:0] obs(input int sel);
        if (sel == 0)
            return {bus_a.tx_start_o, bus_a.tx_bit_o, bus_a.tx_strobe_o,
                    bus_a.busy_o, bus_a.done_o, bus_a.drop_o};
        return {bus_b.tx_start_o, bus_b.tx_bit_o, bus_b.tx_strobe_o,
                bus_b.busy_o, bus_b.done_o, bus_b.drop_o};
    endfunction

    task automatic check(input string name, input int cyc, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got {start,bit,strobe,busy,done,drop}=%b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic frame(input vec_t v, input bit skip_send, input bit chain,
                         input logic [7:0] cd, input logic [3:0] cf);
        int          bc;
        int          n;
        int          p;
        int          off;
        int          strobes;
        logic        eb;
        logic [5:0]  exp;
        logic [5:0]  act;
        logic [7:0]  d;
        logic [3:0]  f;
        bc      = (v.sel == 0) ? 4 : 2;
        n       = 15 * bc;
        strobes = 0;
        d       = v.d;
        f       = v.f;
        if (!skip_send) begin
            @(posedge clk);
            #1;
            drive(v.sel, 1'b1, d, f);
        end
        for (int t = 1; t <= n + 1; t++) begin
            @(posedge clk);
            #1;
            if (t == v.chg) begin
                d = 8'hFF;
                f = ~v.f;
            end
            if (t == n + 1 && chain)
                drive(v.sel, 1'b1, cd, cf);
            else
                drive(v.sel, (t == v.drop_a) || (t == v.drop_b), d, f);
            #4;
            act = obs(v.sel);
            if (t <= n) begin
                p   = (t - 1) / bc;
                off = (t - 1) % bc;
                if (p == 0)       eb = 1'b0;
                else if (p <= 12) eb = v.bits[12 - p];
                else if (p == 13) eb = v.par;
                else              eb = 1'b1;
                exp = {(p == 0), eb, (off == bc / 2), 1'b1, (t == n),
                       ((t == v.drop_a) || (t == v.drop_b))};
            end else begin
                exp = 6'b000000;
            end
            if (act[3]) strobes++;
            check("frame", t, act, exp);
        end
        checks++;
        if (strobes != 15) begin
            errors++;
            $display("FAIL strobe_count got %0d expected 15", strobes);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(0, 1'b0, 8'h00, 4'h0);
        drive(1, 1'b0, 8'h00, 4'h0);

        vecs[0] = '{0, 8'hA5, 4'b0011, 12'b1010_0101_1100, 1'b0, -1, -1, -1};
        vecs[1] = '{0, 8'h01, 4'b0000, 12'b0000_0001_0000, 1'b1, -1, -1, -1};
        vecs[2] = '{0, 8'hA5, 4'b0011, 12'b1010_0101_1100, 1'b0, 10, -1, -1};
        vecs[3] = '{0, 8'h3C, 4'b1000, 12'b0011_1100_0001, 1'b1, -1, -1, -1};
        vecs[4] = '{0, 8'h80, 4'b0100, 12'b1000_0000_0010, 1'b0, -1, -1, -1};
        vecs[5] = '{1, 8'hFF, 4'b1111, 12'b1111_1111_1111, 1'b0, -1, -1, -1};

        // reset state of both instances
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #5;
        end
        check("reset_a", 0, obs(0), 6'b000000);
        check("reset_b", 0, obs(1), 6'b000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        check("idle_a", 0, obs(0), 6'b000000);

        for (int i = 0; i < 6; i++) begin
            frame(vecs[i], 1'b0, 1'b0, 8'h00, 4'h0);
        end

        // requests at the mid-frame and done cycles are dropped; the first idle cycle accepts
        v_drop = '{0, 8'hA5, 4'b0011, 12'b1010_0101_1100, 1'b0, -1, 30, 60};
        v_next = '{0, 8'h01, 4'b0000, 12'b0000_0001_0000, 1'b1, -1, -1, -1};
        frame(v_drop, 1'b0, 1'b1, 8'h01, 4'b0000);
        frame(v_next, 1'b1, 1'b0, 8'h00, 4'h0);

        // reset mid-DATA abandons the frame, then a clean frame follows
        @(posedge clk);
        #1;
        drive(0, 1'b1, 8'hA5, 4'b0011);
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk);
            #1;
            drive(0, 1'b0, 8'hA5, 4'b0011);
            if (t == 20) rst = 1'b1;
            #4;
            if (t == 19) check("busy_before_rst", t, obs(0) & 6'b000100, 6'b000100);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        check("after_rst", 21, obs(0), 6'b000000);
        for (int t = 22; t <= 24; t++) begin
            @(posedge clk);
            #5;
            check("idle_after_rst", t, obs(0), 6'b000000);
        end
        frame(vecs[0], 1'b0, 1'b0, 8'h00, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
